// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - watch time-setting FSM: button edges, inc/clear strobes, auto-repeat, timeout, blink
module time_set_controller #(
    parameter int TICK_DIV   = 500_000,
    parameter int LONG_PRESS = 100,
    parameter int REPEAT     = 20,
    parameter int TIMEOUT    = 1000,
    parameter int BLINK_HALF = 25
) (
    input  logic       Clk_50Mhz,
    input  logic       Reset,
    input  logic       Mode_Btn,
    input  logic       Set_Btn,
    output logic [1:0] Set_Mode,
    output logic       Inc_Hour,
    output logic       Inc_Min,
    output logic       Clr_Sec,
    output logic       Run_En,
    output logic       Blink
);
    localparam int MAX_AB = (LONG_PRESS > REPEAT) ? LONG_PRESS : REPEAT;
    localparam int MAX_CD = (TIMEOUT > BLINK_HALF) ? TIMEOUT : BLINK_HALF;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P + 1);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              mode_prev_q, mode_prev_d;
    logic              set_prev_q, set_prev_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              rep_phase_q, rep_phase_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              inc_hour_q, inc_hour_d;
    logic              inc_min_q, inc_min_d;
    logic              clr_sec_q, clr_sec_d;
    logic              run_en_q, run_en_d;

    logic             tick, mode_rise, set_rise, in_set, can_repeat;
    logic             press_strobe, repeat_fire, strobe, state_chg;
    logic [CNT_W-1:0] hold_thr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        tick        = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
        mode_rise   = Mode_Btn & ~mode_prev_q;
        set_rise    = Set_Btn & ~set_prev_q;
        mode_prev_d = Mode_Btn;
        set_prev_d  = Set_Btn;
        in_set      = (state_q != ST_RUN);
        can_repeat  = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

        // First repeat waits LONG_PRESS ticks, later ones REPEAT ticks
        hold_thr     = rep_phase_q ? CNT_W'(REPEAT - 1) : CNT_W'(LONG_PRESS - 1);
        press_strobe = set_rise & ~mode_rise & in_set;
        repeat_fire  = armed_q & Set_Btn & ~mode_rise & tick & can_repeat & (hold_q == hold_thr);
        strobe       = press_strobe | repeat_fire;

        state_d = state_q;
        if (mode_rise) begin
            state_d = state_t'(state_q + 2'd1);
        end else if (in_set && tick && !strobe && (idle_q == CNT_W'(TIMEOUT - 1))) begin
            state_d = ST_RUN;
        end
        state_chg = (state_d != state_q);

        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        if (set_rise || !Set_Btn) begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
        end else if (repeat_fire) begin
            hold_d      = '0;
            rep_phase_d = 1'b1;
        end else if (tick) begin
            hold_d = sat_inc(hold_q);
        end

        // A Mode edge disarms repeat until Set is released and pressed again
        armed_d = armed_q;
        if (mode_rise) begin
            armed_d = 1'b0;
        end else if (set_rise) begin
            armed_d = 1'b1;
        end else if (!Set_Btn) begin
            armed_d = 1'b0;
        end

        idle_d = idle_q;
        if ((state_d == ST_RUN) || state_chg || mode_rise || set_rise || strobe) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = sat_inc(idle_q);
        end

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if ((state_d == ST_RUN) || state_chg || strobe) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (tick) begin
            if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = sat_inc(blink_cnt_q);
            end
        end

        inc_hour_d = strobe & (state_q == ST_SET_HOUR);
        inc_min_d  = strobe & (state_q == ST_SET_MIN);
        clr_sec_d  = strobe & (state_q == ST_SET_SEC);
        run_en_d   = (state_d != ST_SET_SEC);
    end

    always_ff @(posedge Clk_50Mhz) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            tick_cnt_q  <= '0;
            mode_prev_q <= 1'b1;
            set_prev_q  <= 1'b1;
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
            armed_q     <= 1'b0;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            inc_hour_q  <= 1'b0;
            inc_min_q   <= 1'b0;
            clr_sec_q   <= 1'b0;
            run_en_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            mode_prev_q <= mode_prev_d;
            set_prev_q  <= set_prev_d;
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
            armed_q     <= armed_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            inc_hour_q  <= inc_hour_d;
            inc_min_q   <= inc_min_d;
            clr_sec_q   <= clr_sec_d;
            run_en_q    <= run_en_d;
        end
    end

    assign Set_Mode = state_q;
    assign Inc_Hour = inc_hour_q;
    assign Inc_Min  = inc_min_q;
    assign Clr_Sec  = clr_sec_q;
    assign Run_En   = run_en_q;
    assign Blink    = blink_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - scoreboard bench for time_set_controller
module tb_time_set_controller;
    localparam int TD = 4, LP = 3, RP = 2, TO = 10, BH = 2;

    logic       clk = 1'b0;
    logic       rst, mode_btn, set_btn;
    logic [1:0] set_mode;
    logic       inc_hour, inc_min, clr_sec, run_en, blink;

    time_set_controller #(
        .TICK_DIV(TD), .LONG_PRESS(LP), .REPEAT(RP), .TIMEOUT(TO), .BLINK_HALF(BH)
    ) dut (
        .Clk_50Mhz(clk), .Reset(rst), .Mode_Btn(mode_btn), .Set_Btn(set_btn),
        .Set_Mode(set_mode), .Inc_Hour(inc_hour), .Inc_Min(inc_min), .Clr_Sec(clr_sec),
        .Run_En(run_en), .Blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int at; } sb_t;
    sb_t sb[$];
    int  total = 0, bad = 0, ecnt = 0, cur_mode = 0;
    int  n_str[4] = '{0, 0, 0, 0};
    int  mon_kind;
    sb_t mon_e;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // edges since the last reset edge; tick edges are the positive multiples of TD
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && (inc_hour || inc_min || clr_sec)) begin
            mon_kind = inc_hour ? 1 : (inc_min ? 2 : 3);
            n_str[mon_kind]++;
            check_val("strobe_onehot", int'(inc_hour) + int'(inc_min) + int'(clr_sec), 1);
            if (sb.size() == 0) begin
                check_val("strobe_unexpected", mon_kind, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("strobe_kind", mon_kind, mon_e.kind);
                check_val("strobe_edge", ecnt, mon_e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int e);
        for (int i = 0; i < 4000 && ecnt < e; i++) step();
    endtask

    function automatic int next_tick(input int e);
        return (e / TD + 1) * TD;
    endfunction

    task automatic push(input int kind, input int at);
        sb_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic press_mode();
        int nxt;
        nxt = (cur_mode + 1) % 4;
        mode_btn = 1'b1;
        check_val("mode_pre", int'(set_mode), cur_mode);
        step();
        check_val("mode_next", int'(set_mode), nxt);
        check_val("mode_run_en", int'(run_en), (nxt == 3) ? 0 : 1);
        check_val("mode_blink", int'(blink), 1);
        cur_mode = nxt;
        mode_btn = 1'b0;
        step();
    endtask

    // hold Set for a number of ticks; expected strobes go to the scoreboard up front
    task automatic hold_set(input int ticks, input int kind, input bit rep);
        int p, t1;
        set_btn = 1'b1;
        p  = ecnt + 1;
        t1 = next_tick(p);
        if (kind != 0) begin
            push(kind, p);
            if (rep) for (int j = LP; j <= ticks; j += RP) push(kind, t1 + TD * (j - 1));
        end
        run_to(t1 + TD * (ticks - 1));
        set_btn = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=%0d exp=%0d", ecnt, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t, p, tn, base;
        rst = 1'b1; mode_btn = 1'b1; set_btn = 1'b0;
        repeat (3) step();
        check_val("rst_mode", int'(set_mode), 0);
        check_val("rst_strobes", int'(inc_hour) + int'(inc_min) + int'(clr_sec), 0);
        check_val("rst_run_en", int'(run_en), 1);
        check_val("rst_blink", int'(blink), 1);
        rst = 1'b0;
        repeat (6) step();
        check_val("held_mode_no_edge", int'(set_mode), 0);
        check_val("held_mode_blink", int'(blink), 1);
        mode_btn = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            press_mode();
            step();
        end

        // plain idle timeout
        press_mode(); k = ecnt - 1;
        t = next_tick(k) + (TO - 1) * TD;
        run_to(t - 1);
        check_val("idle_before", int'(set_mode), 1);
        step();
        check_val("idle_timeout", int'(set_mode), 0);
        check_val("idle_run_en", int'(run_en), 1);
        cur_mode = 0;

        // Set press at tick 9 pushes the timeout out
        press_mode(); k = ecnt - 1;
        run_to(next_tick(k) + 8 * TD);
        set_btn = 1'b1; p = ecnt + 1; push(1, p); step();
        set_btn = 1'b0; step();
        run_to(next_tick(k) + 9 * TD);
        check_val("idle_press_extends", int'(set_mode), 1);
        tn = next_tick(p) + 9 * TD;
        run_to(tn - 1);
        check_val("idle_press_before", int'(set_mode), 1);
        step();
        check_val("idle_press_timeout", int'(set_mode), 0);
        cur_mode = 0;

        // blink phase and restart on strobe
        press_mode(); k = ecnt - 1; t = next_tick(k);
        check_val("blink_entry", int'(blink), 1);
        run_to(t + TD - 1);
        check_val("blink_hold", int'(blink), 1);
        step();
        check_val("blink_toggle", int'(blink), 0);
        run_to(t + 2 * TD);
        check_val("blink_low", int'(blink), 0);
        set_btn = 1'b1; p = ecnt + 1; push(1, p); step();
        check_val("blink_forced", int'(blink), 1);
        set_btn = 1'b0;
        run_to(t + 3 * TD);
        check_val("blink_restart", int'(blink), 1);
        run_to(t + 4 * TD);
        check_val("blink_retoggle", int'(blink), 0);
        tn = next_tick(p) + 9 * TD;
        run_to(tn);
        check_val("blink_timeout", int'(set_mode), 0);
        cur_mode = 0;

        // auto-repeat in SET_MIN, single clear in SET_SEC, nothing in RUN
        press_mode(); press_mode();
        base = n_str[2];
        hold_set(12, 2, 1'b1);
        check_val("min_repeat_count", n_str[2] - base, 6);
        check_val("min_still_set", int'(set_mode), 2);
        press_mode();
        base = n_str[3];
        hold_set(12, 3, 1'b0);
        check_val("sec_clear_count", n_str[3] - base, 1);
        check_val("sec_timeout", int'(set_mode), 0);
        cur_mode = 0;
        base = n_str[1] + n_str[2] + n_str[3];
        hold_set(12, 0, 1'b0);
        check_val("run_no_strobe", n_str[1] + n_str[2] + n_str[3] - base, 0);
        check_val("run_mode", int'(set_mode), 0);

        // Mode and Set rise together: Mode wins, no repeat
        press_mode();
        mode_btn = 1'b1; set_btn = 1'b1; step(); k = ecnt;
        check_val("simul_mode", int'(set_mode), 2);
        mode_btn = 1'b0;
        run_to(next_tick(k) + 9 * TD);
        set_btn = 1'b0; step();
        check_val("simul_timeout", int'(set_mode), 0);
        cur_mode = 0;

        // Mode while Set held disarms repeat until a fresh press
        press_mode();
        set_btn = 1'b1; p = ecnt + 1; push(1, p); step(); t = next_tick(p);
        run_to(t + TD);
        mode_btn = 1'b1; step(); k = ecnt; cur_mode = 2;
        check_val("held_mode_change", int'(set_mode), 2);
        mode_btn = 1'b0;
        run_to(next_tick(k) + 5 * TD);
        set_btn = 1'b0; step();
        hold_set(4, 2, 1'b1);
        check_val("rearm_mode", int'(set_mode), 2);

        // reset during repeat
        press_mode(); press_mode(); press_mode();
        set_btn = 1'b1; p = ecnt + 1; push(1, p); step(); t = next_tick(p);
        push(1, t + 2 * TD);
        run_to(t + 3 * TD + 1);
        rst = 1'b1; step();
        check_val("rst_mid_mode", int'(set_mode), 0);
        check_val("rst_mid_strobe", int'(inc_hour) + int'(inc_min) + int'(clr_sec), 0);
        check_val("rst_mid_run_en", int'(run_en), 1);
        check_val("rst_mid_blink", int'(blink), 1);
        rst = 1'b0; cur_mode = 0;
        run_to(10 * TD);
        check_val("rst_after_hold", int'(set_mode), 0);
        set_btn = 1'b0;
        repeat (4) step();
        check_val("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
